multi_cycle_ctrl: RTL and testbench
===================================

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port opcode, input, 6 bits: Instruct[31:26] from the instruction register; stable from DECODE onward.
REQ-004 SHALL have port funct, input, 6 bits: Instruct[5:0].
REQ-005 SHALL have port cond, input, 1 bit: ALUOut[0] branch-taken flag, valid in EXEC.
REQ-006 SHALL have port irq, input, 1 bit: interrupt request from the peripheral block.
REQ-007 SHALL have port pc_sup, input, 1 bit: PC[31], the kernel-mode bit.
REQ-008 SHALL have outputs pc_wr, ir_wr, mem_rd, mem_wr, reg_wr, 1 bit each: write/read strobes.
REQ-009 SHALL have outputs i_or_d (1 bit), alu_src_a (1 bit), alu_src_b (2 bits), reg_dst (2 bits), mem_to_reg (2 bits), pc_src (3 bits): datapath mux selects.
REQ-010 SHALL have output state, 3 bits: current FSM state; output retired, 32 bits: retired-instruction count.

Function
REQ-011 SHALL implement a Moore FSM: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 return to FETCH.
REQ-012 FETCH: mem_rd=1, ir_wr=1, i_or_d=0, alu_src_a=0, alu_src_b=1 (const 4), pc_src=0, pc_wr=1; next state DECODE.
REQ-013 DECODE: alu_src_b=3 (sext imm<<2) precomputes the branch target; next state EXEC, except the trap cases in REQ-019/020.
REQ-014 R-type (opcode 0x00, funct not 0x08/0x09): EXEC then WB with reg_dst=0, mem_to_reg=0, reg_wr=1; 4 cycles total.
REQ-015 jr (0x00/0x08): EXEC pc_src=3, pc_wr=1; jalr (0x00/0x09) additionally writes reg_dst=0, mem_to_reg=2, reg_wr=1; 3 cycles.
REQ-016 lw 0x23: EXEC, then MEM (mem_rd=1, i_or_d=1), then WB (reg_dst=1, mem_to_reg=1); 5 cycles. sw 0x2b: EXEC, then MEM (mem_wr=1, i_or_d=1); 4 cycles.
REQ-017 I-type ALU ops 0x08, 0x09, 0x0a, 0x0b, 0x0c, 0x0f: EXEC (alu_src_b=2), then WB (reg_dst=1, mem_to_reg=0); 4 cycles.
REQ-018 Branches 0x01, 0x04-0x07: in EXEC pc_src=1 and pc_wr=cond; j 0x02 / jal 0x03: in EXEC pc_src=2, pc_wr=1, and jal writes reg_dst=2, mem_to_reg=2, reg_wr=1; 3 cycles.
REQ-019 Any other opcode is illegal: DECODE drives pc_src=5 (XADR), pc_wr=1, reg_dst=3, mem_to_reg=2, reg_wr=1; next state FETCH.
REQ-020 Interrupt: irq=1 and pc_sup=0 sampled in DECODE has priority over REQ-019 and drives pc_src=4 (ILLOP), pc_wr=1, reg_dst=3, mem_to_reg=2, reg_wr=1; next state FETCH; the interrupted instruction is not retired.
REQ-021 irq while pc_sup=1, or in any state other than DECODE, SHALL be ignored with no latching.
REQ-022 All outputs not named for a state SHALL be 0; mem_wr and mem_rd SHALL never both be 1.
REQ-023 retired SHALL increment by 1 on the last cycle of each completed instruction, exclude traps, and wrap from 0xFFFFFFFF to 0.

Reset
REQ-024 reset=0 SHALL force state=FETCH and retired=0 asynchronously; strobes SHALL follow FETCH decode.
REQ-025 Reset asserted mid-instruction SHALL abandon the instruction with no further MEM or WB strobes after release.

Configuration
REQ-026 With MULTI_CYCLE_CTRL_IRQ_EN defined, REQ-020 SHALL apply; without it, irq SHALL be ignored and the port kept for pin compatibility.

Structure
REQ-027 State codes, opcode/funct constants and pc_src/reg_dst/mem_to_reg encodings SHALL reside in shared package cpu_ctrl_pkg.
REQ-028 Opcode classification (R/JR/JALR/LW/SW/IALU/BR/J/JAL/ILL) SHALL be a combinational sub-module ctrl_decode; the FSM and counter SHALL stay in the top module.

Verification
REQ-029 add (0x00/0x20) after reset: state sequence 0,1,2,4,0; reg_wr=1 only in WB; retired goes 0 to 1.
REQ-030 lw 0x23: 5 cycles; mem_rd=1 with i_or_d=1 in MEM; reg_wr=1, mem_to_reg=1 in WB.
REQ-031 beq with cond=1, then with cond=0: pc_wr=1 then pc_wr=0 in EXEC; both take 3 cycles.
REQ-032 opcode 0x3F: DECODE pc_src=5, reg_dst=3, reg_wr=1; next state FETCH; retired unchanged.
REQ-033 irq=1 with pc_sup=0 in DECODE of an add: pc_src=4, next state FETCH; the same stimulus with pc_sup=1 gives a normal add; with the macro undefined, it always gives a normal add.
REQ-034 reset pulsed during MEM of sw: state=0 and retired=0 immediately; no mem_wr after release until the next sw reaches MEM.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the multi-cycle CPU control path: state codes, opcode/funct
// values, operation classes and datapath mux encodings.
package cpu_ctrl_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned PCSRC_W = 3;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned CNT_W   = 32;

  // FSM state codes; 5-7 are unused and fall back to FETCH
  localparam logic [STATE_W-1:0] ST_FETCH  = 3'd0;
  localparam logic [STATE_W-1:0] ST_DECODE = 3'd1;
  localparam logic [STATE_W-1:0] ST_EXEC   = 3'd2;
  localparam logic [STATE_W-1:0] ST_MEM    = 3'd3;
  localparam logic [STATE_W-1:0] ST_WB     = 3'd4;

  // Opcodes (Instruct[31:26])
  localparam logic [OP_W-1:0] OP_RTYPE  = 6'h00;
  localparam logic [OP_W-1:0] OP_REGIMM = 6'h01;
  localparam logic [OP_W-1:0] OP_J      = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL    = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ    = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE    = 6'h05;
  localparam logic [OP_W-1:0] OP_BLEZ   = 6'h06;
  localparam logic [OP_W-1:0] OP_BGTZ   = 6'h07;
  localparam logic [OP_W-1:0] OP_ADDI   = 6'h08;
  localparam logic [OP_W-1:0] OP_ADDIU  = 6'h09;
  localparam logic [OP_W-1:0] OP_SLTI   = 6'h0a;
  localparam logic [OP_W-1:0] OP_SLTIU  = 6'h0b;
  localparam logic [OP_W-1:0] OP_ANDI   = 6'h0c;
  localparam logic [OP_W-1:0] OP_LUI    = 6'h0f;
  localparam logic [OP_W-1:0] OP_LW     = 6'h23;
  localparam logic [OP_W-1:0] OP_SW     = 6'h2b;

  // Function codes (Instruct[5:0]) that change R-type behaviour
  localparam logic [OP_W-1:0] FN_JR   = 6'h08;
  localparam logic [OP_W-1:0] FN_JALR = 6'h09;

  // pc_src encodings
  localparam logic [PCSRC_W-1:0] PC_SRC_ALU    = 3'd0;
  localparam logic [PCSRC_W-1:0] PC_SRC_ALUOUT = 3'd1;
  localparam logic [PCSRC_W-1:0] PC_SRC_JUMP   = 3'd2;
  localparam logic [PCSRC_W-1:0] PC_SRC_REG    = 3'd3;
  localparam logic [PCSRC_W-1:0] PC_SRC_ILLOP  = 3'd4;
  localparam logic [PCSRC_W-1:0] PC_SRC_XADR   = 3'd5;

  // reg_dst encodings
  localparam logic [SEL_W-1:0] REG_DST_RD = 2'd0;
  localparam logic [SEL_W-1:0] REG_DST_RT = 2'd1;
  localparam logic [SEL_W-1:0] REG_DST_RA = 2'd2;
  localparam logic [SEL_W-1:0] REG_DST_XP = 2'd3;

  // mem_to_reg encodings
  localparam logic [SEL_W-1:0] M2R_ALU = 2'd0;
  localparam logic [SEL_W-1:0] M2R_MEM = 2'd1;
  localparam logic [SEL_W-1:0] M2R_PC  = 2'd2;

  // alu_src_b encodings
  localparam logic [SEL_W-1:0] ALUB_REG   = 2'd0;
  localparam logic [SEL_W-1:0] ALUB_FOUR  = 2'd1;
  localparam logic [SEL_W-1:0] ALUB_IMM   = 2'd2;
  localparam logic [SEL_W-1:0] ALUB_IMMSH = 2'd3;

  typedef enum logic [3:0] {
    CLS_R    = 4'd0,
    CLS_JR   = 4'd1,
    CLS_JALR = 4'd2,
    CLS_LW   = 4'd3,
    CLS_SW   = 4'd4,
    CLS_IALU = 4'd5,
    CLS_BR   = 4'd6,
    CLS_J    = 4'd7,
    CLS_JAL  = 4'd8,
    CLS_ILL  = 4'd9
  } op_class_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct classifier for the multi-cycle controller.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  input  logic [OP_W-1:0] funct,
  output op_class_e       op_class_c
);

  // Map the instruction fields onto one operation class
  always_comb begin
    op_class_c = CLS_ILL;
    case (opcode)
      OP_RTYPE: begin
        if (funct == FN_JR)        op_class_c = CLS_JR;
        else if (funct == FN_JALR) op_class_c = CLS_JALR;
        else                       op_class_c = CLS_R;
      end
      OP_LW:  op_class_c = CLS_LW;
      OP_SW:  op_class_c = CLS_SW;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_LUI:
        op_class_c = CLS_IALU;
      OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:
        op_class_c = CLS_BR;
      OP_J:   op_class_c = CLS_J;
      OP_JAL: op_class_c = CLS_JAL;
      default: op_class_c = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Moore control FSM for a multi-cycle MIPS-style datapath with a retired-instruction
// counter. Define MULTI_CYCLE_CTRL_IRQ_EN to let irq (sampled in DECODE while not in
// kernel mode) trap to the ILLOP vector; otherwise irq is ignored.
module multi_cycle_ctrl
  import cpu_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    opcode,
  input  logic [OP_W-1:0]    funct,
  input  logic               cond,
  input  logic               irq,
  input  logic               pc_sup,
  output logic               pc_wr,
  output logic               ir_wr,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic               reg_wr,
  output logic               i_or_d,
  output logic               alu_src_a,
  output logic [SEL_W-1:0]   alu_src_b,
  output logic [SEL_W-1:0]   reg_dst,
  output logic [SEL_W-1:0]   mem_to_reg,
  output logic [PCSRC_W-1:0] pc_src,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   retired
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               retire_c;
  logic               irq_take_c;
  op_class_e          op_class_c;

  ctrl_decode u_decode (
    .opcode     (opcode),
    .funct      (funct),
    .op_class_c (op_class_c)
  );

`ifdef MULTI_CYCLE_CTRL_IRQ_EN
  // Interrupts are only honoured outside kernel mode
  assign irq_take_c = irq & ~pc_sup;
`else
  // irq/pc_sup kept as pins only
  logic unused_irq;
  assign unused_irq = irq ^ pc_sup;
  assign irq_take_c = 1'b0;
`endif

  // State and retired-count registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Next-state logic; retire_c marks the final cycle of a completed instruction
  always_comb begin
    state_d  = ST_FETCH;
    retire_c = 1'b0;
    case (state_q)
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        if (irq_take_c || (op_class_c == CLS_ILL)) state_d = ST_FETCH;
        else                                       state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (op_class_c)
          CLS_R, CLS_IALU: state_d = ST_WB;
          CLS_LW, CLS_SW:  state_d = ST_MEM;
          CLS_JR, CLS_JALR, CLS_BR, CLS_J, CLS_JAL: begin
            state_d  = ST_FETCH;
            retire_c = 1'b1;
          end
          default: state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (op_class_c == CLS_LW) begin
          state_d = ST_WB;
        end else begin
          state_d  = ST_FETCH;
          retire_c = (op_class_c == CLS_SW);
        end
      end
      ST_WB: begin
        state_d  = ST_FETCH;
        retire_c = 1'b1;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Retired counter wraps naturally at 2^32
  always_comb begin
    retired_d = retired_q;
    if (retire_c) retired_d = retired_q + CNT_W'(1);
  end

  // Moore output decode from the current state
  always_comb begin
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    reg_wr     = 1'b0;
    i_or_d     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = ALUB_REG;
    reg_dst    = REG_DST_RD;
    mem_to_reg = M2R_ALU;
    pc_src     = PC_SRC_ALU;
    case (state_q)
      ST_FETCH: begin
        mem_rd    = 1'b1;
        ir_wr     = 1'b1;
        alu_src_b = ALUB_FOUR;
        pc_wr     = 1'b1;
      end
      ST_DECODE: begin
        alu_src_b = ALUB_IMMSH;
        if (irq_take_c || (op_class_c == CLS_ILL)) begin
          pc_src     = irq_take_c ? PC_SRC_ILLOP : PC_SRC_XADR;
          pc_wr      = 1'b1;
          reg_dst    = REG_DST_XP;
          mem_to_reg = M2R_PC;
          reg_wr     = 1'b1;
        end
      end
      ST_EXEC: begin
        case (op_class_c)
          CLS_IALU: alu_src_b = ALUB_IMM;
          CLS_JR: begin
            pc_src = PC_SRC_REG;
            pc_wr  = 1'b1;
          end
          CLS_JALR: begin
            pc_src     = PC_SRC_REG;
            pc_wr      = 1'b1;
            reg_dst    = REG_DST_RD;
            mem_to_reg = M2R_PC;
            reg_wr     = 1'b1;
          end
          CLS_BR: begin
            pc_src = PC_SRC_ALUOUT;
            pc_wr  = cond;
          end
          CLS_J: begin
            pc_src = PC_SRC_JUMP;
            pc_wr  = 1'b1;
          end
          CLS_JAL: begin
            pc_src     = PC_SRC_JUMP;
            pc_wr      = 1'b1;
            reg_dst    = REG_DST_RA;
            mem_to_reg = M2R_PC;
            reg_wr     = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        if (op_class_c == CLS_LW) begin
          mem_rd = 1'b1;
          i_or_d = 1'b1;
        end else if (op_class_c == CLS_SW) begin
          mem_wr = 1'b1;
          i_or_d = 1'b1;
        end
      end
      ST_WB: begin
        reg_wr = 1'b1;
        if (op_class_c == CLS_LW) begin
          reg_dst    = REG_DST_RT;
          mem_to_reg = M2R_MEM;
        end else if (op_class_c == CLS_IALU) begin
          reg_dst = REG_DST_RT;
        end
      end
      default: ;
    endcase
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed self-checking bench for multi_cycle_ctrl.
module tb_multi_cycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        cond;
  logic        irq;
  logic        pc_sup;
  logic        pc_wr, ir_wr, mem_rd, mem_wr, reg_wr, i_or_d, alu_src_a;
  logic [1:0]  alu_src_b, reg_dst, mem_to_reg;
  logic [2:0]  pc_src;
  logic [2:0]  state;
  logic [31:0] retired;

  int n_checks = 0;
  int n_fail   = 0;

  multi_cycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .cond       (cond),
    .irq        (irq),
    .pc_sup     (pc_sup),
    .pc_wr      (pc_wr),
    .ir_wr      (ir_wr),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .reg_wr     (reg_wr),
    .i_or_d     (i_or_d),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .pc_src     (pc_src),
    .state      (state),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
  endtask

  // Per-cycle sanity: the memory strobes are mutually exclusive
  task automatic check_excl(input string tag);
    check_eq(tag, 32'(mem_rd & mem_wr), 32'd0);
  endtask

  int exp_ret;

  initial begin
    reset = 1'b0; opcode = 6'h00; funct = 6'h20; cond = 1'b0; irq = 1'b0; pc_sup = 1'b0;
    exp_ret = 0;
    #12;
    // Reset: FETCH decode active during reset
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_retired", retired, 32'd0);
    check_eq("rst_mem_rd", 32'(mem_rd), 32'd1);
    check_eq("rst_ir_wr", 32'(ir_wr), 32'd1);
    check_eq("rst_pc_wr", 32'(pc_wr), 32'd1);
    check_eq("rst_alu_b", 32'(alu_src_b), 32'd1);
    check_eq("rst_reg_wr", 32'(reg_wr), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // add: 0,1,2,4,0 and reg_wr only in WB
    set_instr(6'h00, 6'h20);
    tick();
    check_eq("add_dec_state", 32'(state), 32'd1);
    check_eq("add_dec_alub", 32'(alu_src_b), 32'd3);
    check_eq("add_dec_regwr", 32'(reg_wr), 32'd0);
    check_eq("add_dec_pcwr", 32'(pc_wr), 32'd0);
    tick();
    check_eq("add_exe_state", 32'(state), 32'd2);
    check_eq("add_exe_regwr", 32'(reg_wr), 32'd0);
    tick();
    check_eq("add_wb_state", 32'(state), 32'd4);
    check_eq("add_wb_regwr", 32'(reg_wr), 32'd1);
    check_eq("add_wb_regdst", 32'(reg_dst), 32'd0);
    check_eq("add_wb_m2r", 32'(mem_to_reg), 32'd0);
    tick();
    exp_ret++;
    check_eq("add_end_state", 32'(state), 32'd0);
    check_eq("add_retired", retired, 32'(exp_ret));

    // lw: 5 cycles
    set_instr(6'h23, 6'h00);
    tick(); check_eq("lw_dec_state", 32'(state), 32'd1);
    tick(); check_eq("lw_exe_state", 32'(state), 32'd2);
    tick();
    check_eq("lw_mem_state", 32'(state), 32'd3);
    check_eq("lw_mem_rd", 32'(mem_rd), 32'd1);
    check_eq("lw_mem_iord", 32'(i_or_d), 32'd1);
    check_eq("lw_mem_wr", 32'(mem_wr), 32'd0);
    tick();
    check_eq("lw_wb_state", 32'(state), 32'd4);
    check_eq("lw_wb_regwr", 32'(reg_wr), 32'd1);
    check_eq("lw_wb_m2r", 32'(mem_to_reg), 32'd1);
    check_eq("lw_wb_regdst", 32'(reg_dst), 32'd1);
    tick();
    exp_ret++;
    check_eq("lw_end_state", 32'(state), 32'd0);
    check_eq("lw_retired", retired, 32'(exp_ret));

    // beq taken then not taken
    for (int k = 0; k < 2; k++) begin
      set_instr(6'h04, 6'h00);
      cond = (k == 0);
      tick(); check_eq("beq_dec_state", 32'(state), 32'd1);
      tick();
      check_eq("beq_exe_state", 32'(state), 32'd2);
      check_eq("beq_pc_src", 32'(pc_src), 32'd1);
      check_eq("beq_pc_wr", 32'(pc_wr), (k == 0) ? 32'd1 : 32'd0);
      tick();
      exp_ret++;
      check_eq("beq_end_state", 32'(state), 32'd0);
      check_eq("beq_retired", retired, 32'(exp_ret));
    end
    cond = 1'b0;

    // illegal opcode traps from DECODE
    set_instr(6'h3f, 6'h00);
    tick();
    check_eq("ill_state", 32'(state), 32'd1);
    check_eq("ill_pc_src", 32'(pc_src), 32'd5);
    check_eq("ill_pc_wr", 32'(pc_wr), 32'd1);
    check_eq("ill_regdst", 32'(reg_dst), 32'd3);
    check_eq("ill_m2r", 32'(mem_to_reg), 32'd2);
    check_eq("ill_regwr", 32'(reg_wr), 32'd1);
    tick();
    check_eq("ill_next_state", 32'(state), 32'd0);
    check_eq("ill_retired", retired, 32'(exp_ret));

    // jalr
    set_instr(6'h00, 6'h09);
    tick();
    tick();
    check_eq("jalr_exe_state", 32'(state), 32'd2);
    check_eq("jalr_pc_src", 32'(pc_src), 32'd3);
    check_eq("jalr_pc_wr", 32'(pc_wr), 32'd1);
    check_eq("jalr_regwr", 32'(reg_wr), 32'd1);
    check_eq("jalr_m2r", 32'(mem_to_reg), 32'd2);
    tick();
    exp_ret++;
    check_eq("jalr_end_state", 32'(state), 32'd0);
    check_eq("jalr_retired", retired, 32'(exp_ret));

    // jal
    set_instr(6'h03, 6'h00);
    tick();
    tick();
    check_eq("jal_pc_src", 32'(pc_src), 32'd2);
    check_eq("jal_regdst", 32'(reg_dst), 32'd2);
    check_eq("jal_regwr", 32'(reg_wr), 32'd1);
    tick();
    exp_ret++;
    check_eq("jal_end_state", 32'(state), 32'd0);
    check_eq("jal_retired", retired, 32'(exp_ret));

    // addi
    set_instr(6'h08, 6'h00);
    tick();
    tick();
    check_eq("addi_exe_alub", 32'(alu_src_b), 32'd2);
    tick();
    check_eq("addi_wb_state", 32'(state), 32'd4);
    check_eq("addi_wb_regdst", 32'(reg_dst), 32'd1);
    check_eq("addi_wb_regwr", 32'(reg_wr), 32'd1);
    tick();
    exp_ret++;
    check_eq("addi_retired", retired, 32'(exp_ret));

    // irq in DECODE of an add, user mode
    set_instr(6'h00, 6'h20);
    irq = 1'b1; pc_sup = 1'b0;
    tick();
`ifdef MULTI_CYCLE_CTRL_IRQ_EN
    check_eq("irq_pc_src", 32'(pc_src), 32'd4);
    check_eq("irq_regwr", 32'(reg_wr), 32'd1);
    tick();
    check_eq("irq_next_state", 32'(state), 32'd0);
    check_eq("irq_retired", retired, 32'(exp_ret));
`else
    check_eq("irq_off_pc_src", 32'(pc_src), 32'd0);
    check_eq("irq_off_regwr", 32'(reg_wr), 32'd0);
    tick();
    check_eq("irq_off_exe", 32'(state), 32'd2);
    tick();
    check_eq("irq_off_wb", 32'(state), 32'd4);
    tick();
    exp_ret++;
    check_eq("irq_off_retired", retired, 32'(exp_ret));
`endif

    // irq in kernel mode is ignored: normal add
    pc_sup = 1'b1;
    tick();
    check_eq("irqk_pc_src", 32'(pc_src), 32'd0);
    check_eq("irqk_regwr", 32'(reg_wr), 32'd0);
    tick(); check_eq("irqk_exe", 32'(state), 32'd2);
    tick(); check_eq("irqk_wb", 32'(state), 32'd4);
    tick();
    exp_ret++;
    check_eq("irqk_retired", retired, 32'(exp_ret));
    irq = 1'b0; pc_sup = 1'b0;

    // sw completes in 4 cycles
    set_instr(6'h2b, 6'h00);
    tick(); tick(); tick();
    check_eq("sw_mem_state", 32'(state), 32'd3);
    check_eq("sw_mem_wr", 32'(mem_wr), 32'd1);
    check_eq("sw_mem_rd", 32'(mem_rd), 32'd0);
    check_eq("sw_mem_iord", 32'(i_or_d), 32'd1);
    tick();
    exp_ret++;
    check_eq("sw_end_state", 32'(state), 32'd0);
    check_eq("sw_retired", retired, 32'(exp_ret));

    // sw aborted by reset during MEM
    tick(); tick(); tick();
    check_eq("swr_mem_state", 32'(state), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    check_eq("swr_rst_state", 32'(state), 32'd0);
    check_eq("swr_rst_retired", retired, 32'd0);
    check_eq("swr_rst_mem_wr", 32'(mem_wr), 32'd0);
    set_instr(6'h00, 6'h20);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check_eq("swr_no_mem_wr", 32'(mem_wr), 32'd0);
      check_excl("swr_excl");
      tick();
    end
    check_eq("swr_after_retired", retired, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Bound on total run time
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
